// File: rtl/hash_msg_padder.sv
// hash_msg_padder: fetches a byte-length message from the 32-bit SRAM and
// byte-swaps it to big-endian. It appends the 0x80 marker, zero fill and the
// 64-bit bit length, then streams 16-word blocks over a valid/ready port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start
// S_FETCH  | issuing memory reads for message words (m < ceil(size/4))
// S_PAD    | generating marker / zero-fill words
// S_LEN_HI | generating upper 32 bits of the bit length (word NW-2)
// S_LEN_LO | generating lower 32 bits of the bit length (word NW-1)
// S_DRAIN  | all words issued, waiting for the consumer to take w_last
//
// Every word, whether it is read or generated, passes through one in-flight
// stage before it reaches the output register or the skid FIFO. This keeps
// the words in order at the fetch/pad boundary without bubbles. A word is
// issued only when the skid occupancy plus the in-flight stage is below
// FIFO_DEPTH, so a landing word always has a slot.

module hash_msg_padder #(
  parameter int ADDR_W     = 16,
  parameter bit SWAP_BYTES = 1'b1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       size,
  output logic              mem_clk,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_read_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [31:0]       w_data,
  output logic [3:0]        w_idx,
  output logic              w_last,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_PAD, S_LEN_HI, S_LEN_LO, S_DRAIN
  } state_t;

  state_t state_q, state_d;

  // job parameters, latched at start
  logic [31:0]       size_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       nreads_q;
  logic [31:0]       nw_q;
  logic [31:0]       m_q;

  logic [31:0] f_w, nw_m1, nw_m2, m_next;
  logic [1:0]  r_w;
  logic [31:0] job_nreads, job_blocks, job_nw;

  // in-flight stage
  logic        stage_v, stage_mem, stage_last;
  logic [1:0]  stage_r;
  logic [31:0] stage_gen;
  logic [3:0]  stage_idx;

  // skid FIFO
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [3:0]       fifo_idx  [FIFO_DEPTH];
  logic             fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] occ;

  logic        issue, is_rd, start_job, room;
  logic [31:0] gen_word, mem_swapped, land_data;
  logic        pop, out_load, fifo_push, fifo_pop;
  logic        unused_addr_bits;

  assign mem_clk          = clk;
  assign unused_addr_bits = ^message_addr[31:ADDR_W];

  assign f_w    = {2'b00, size_q[31:2]};
  assign r_w    = size_q[1:0];
  assign nw_m1  = nw_q - 32'd1;
  assign nw_m2  = nw_q - 32'd2;
  assign m_next = m_q + 32'd1;

  // one block if marker plus length fit after the tail bytes, else two
  assign job_nreads = {2'b00, size[31:2]} + {31'b0, |size[1:0]};
  assign job_blocks = {6'b0, size[31:6]} + ((size[5:0] < 6'd56) ? 32'd1 : 32'd2);
  assign job_nw     = job_blocks << 4;

  assign pop      = w_valid && w_ready;
  assign out_load = !w_valid || pop;
  assign room     = ({1'b0, occ} + (CNT_W + 1)'(stage_v)) < DEPTH_C;
  assign is_rd    = m_q < nreads_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // next-state logic; word kind follows m, the state only tracks the phase
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (issue) begin
                  if (m_next == nw_m2)          state_d = S_LEN_HI;
                  else if (m_next >= nreads_q)  state_d = S_PAD;
                end
      S_PAD:    if (issue && m_next == nw_m2) state_d = S_LEN_HI;
      S_LEN_HI: if (issue) state_d = S_LEN_LO;
      S_LEN_LO: if (issue) state_d = S_DRAIN;
      S_DRAIN:  if (pop && w_last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: issue strobe, memory request, busy
  always_comb begin
    issue     = 1'b0;
    start_job = 1'b0;
    case (state_q)
      S_IDLE:                               start_job = start;
      S_FETCH, S_PAD, S_LEN_HI, S_LEN_LO:   issue     = room;
      default: ;
    endcase
    mem_rd   = issue && is_rd;
    mem_addr = mem_rd ? (base_q + m_q[ADDR_W-1:0]) : '0;
    busy     = (state_q != S_IDLE);
  end

  // generated word for index m (marker when the message ends on a word boundary)
  always_comb begin
    gen_word = 32'h0;
    if (m_q == f_w)        gen_word = 32'h8000_0000;
    else if (m_q == nw_m2) gen_word = {29'b0, size_q[31:29]};
    else if (m_q == nw_m1) gen_word = {size_q[28:0], 3'b000};
  end

  // word landing from the in-flight stage; a partial tail word gets masked and marked
  always_comb begin
    mem_swapped = SWAP_BYTES ? {mem_read_data[7:0], mem_read_data[15:8],
                                mem_read_data[23:16], mem_read_data[31:24]}
                             : mem_read_data;
    case (stage_r)
      2'd1:    land_data = (mem_swapped & 32'hFF00_0000) | 32'h0080_0000;
      2'd2:    land_data = (mem_swapped & 32'hFFFF_0000) | 32'h0000_8000;
      2'd3:    land_data = (mem_swapped & 32'hFFFF_FF00) | 32'h0000_0080;
      default: land_data = mem_swapped;
    endcase
    if (!stage_mem) land_data = stage_gen;
    fifo_pop  = out_load && (occ != '0);
    fifo_push = stage_v && !(out_load && (occ == '0));
  end

  // job registers and word counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      size_q   <= '0;
      base_q   <= '0;
      nreads_q <= '0;
      nw_q     <= '0;
      m_q      <= '0;
    end else if (start_job) begin
      size_q   <= size;
      base_q   <= message_addr[ADDR_W-1:0];
      nreads_q <= job_nreads;
      nw_q     <= job_nw;
      m_q      <= '0;
    end else if (issue) begin
      m_q <= m_next;
    end
  end

  // in-flight stage: memory data arrives one edge after the read is issued
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage_v    <= 1'b0;
      stage_mem  <= 1'b0;
      stage_r    <= 2'd0;
      stage_gen  <= '0;
      stage_idx  <= '0;
      stage_last <= 1'b0;
    end else begin
      stage_v <= issue;
      if (issue) begin
        stage_mem  <= is_rd;
        stage_r    <= (is_rd && m_q == f_w) ? r_w : 2'd0;
        stage_gen  <= gen_word;
        stage_idx  <= m_q[3:0];
        stage_last <= (m_q == nw_m1);
      end
    end
  end

  // output register fed from the FIFO head, or straight from the stage when empty
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_valid <= 1'b0;
      w_data  <= '0;
      w_idx   <= '0;
      w_last  <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      occ     <= '0;
      done    <= 1'b0;
    end else begin
      if (out_load) begin
        if (occ != '0) begin
          w_valid <= 1'b1;
          w_data  <= fifo_data[rd_ptr];
          w_idx   <= fifo_idx[rd_ptr];
          w_last  <= fifo_last[rd_ptr];
        end else if (stage_v) begin
          w_valid <= 1'b1;
          w_data  <= land_data;
          w_idx   <= stage_idx;
          w_last  <= stage_last;
        end else begin
          w_valid <= 1'b0;
        end
      end
      if (fifo_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
      occ  <= occ + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
      done <= (state_q == S_DRAIN) && pop && w_last;
    end
  end

  // skid FIFO storage
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data[wr_ptr] <= land_data;
      fifo_idx[wr_ptr]  <= stage_idx;
      fifo_last[wr_ptr] <= stage_last;
    end
  end

endmodule
